cond_sel_arbiter: RTL and testbench

- Shares one registered 4-bit conditional-select datapath among NREQ requesters: y = (c != 0) ? a : b.
- Arbitration is round-robin. Each requester presents an operand triple {a, b, c} and waits for a one-cycle grant.
- The result is returned over a valid/ready handshake tagged with the requester id.
- Sits between operand producers and a single result consumer in the operator-exercise datapath.

---
 rtl/cond_sel_arbiter_pkg.sv | 27 ++
 rtl/cond_sel_arbiter_rr_pick.sv | 38 +++
 rtl/cond_sel_arbiter.sv | 152 +++++++++++++++
 tb/tb_cond_sel_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cond_sel_arbiter_pkg.sv
// Shared types and constants for the conditional-select arbiter.
//   state_e      : FSM encodings (2'd3 is unused and recovers to IDLE)
//   DEF_NREQ     : default requester count
//   DEF_WIDTH    : default operand/result width
//   clog2()      : ceiling log2 for deriving the id width
package cond_sel_arbiter_pkg;

    localparam int unsigned DEF_NREQ  = 4;
    localparam int unsigned DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Smallest r with 2**r >= v.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < v) r = 32'(i) + 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cond_sel_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req    : request vector
//   ptr    : highest-priority index for this round
//   winner : first set request at or above ptr, wrapping NREQ-1 -> 0
//   any    : at least one request is set
module cond_sel_arbiter_rr_pick
    import cond_sel_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  winner,
    output logic            any
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IDW-1:0]    k;

    // Rotate so that bit 0 of rot is requester ptr.
    assign dbl = {req, req};
    assign rot = dbl[ptr +: NREQ];

    // Lowest set bit of the rotated vector.
    always_comb begin
        k = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot[j]) k = IDW'(j);
        end
    end

    // Unrotate; NREQ is a power of two so the add wraps naturally.
    assign winner = ptr + k;
    assign any    = |req;

endmodule

// File: rtl/cond_sel_arbiter.sv
// Round-robin shared conditional-select unit: y = (c != 0) ? a : b.
//   clk, rst_n          : clock, async active-low reset
//   req                 : per-requester request, held until granted
//   a_in, b_in, c_in    : flattened operands, requester i at [i*WIDTH +: WIDTH]
//   grant               : one-hot one-cycle pulse, operands captured on that edge
//   y_out, y_id,y_valid : result, owner id, valid
//   y_ready             : consumer accept
//   busy                : FSM not idle
module cond_sel_arbiter
    import cond_sel_arbiter_pkg::*;
#(
    parameter int unsigned NREQ  = DEF_NREQ,
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned IDW   = clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    input  logic [NREQ*WIDTH-1:0] c_in,
    output logic [NREQ-1:0]       grant,
    output logic [WIDTH-1:0]      y_out,
    output logic [IDW-1:0]        y_id,
    output logic                  y_valid,
    input  logic                  y_ready,
    output logic                  busy
);

    state_e             state_q, state_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic [WIDTH-1:0]   y_out_q, y_out_d;
    logic [IDW-1:0]     y_id_q, y_id_d;
    logic               y_valid_q, y_valid_d;
    logic               busy_q, busy_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [WIDTH-1:0]   a_lat_q, a_lat_d;
    logic [WIDTH-1:0]   b_lat_q, b_lat_d;
    logic [WIDTH-1:0]   c_lat_q, c_lat_d;
    logic [IDW-1:0]     id_lat_q, id_lat_d;

    logic [IDW-1:0]     winner;
    logic               any;
    logic [WIDTH-1:0]   a_sel, b_sel, c_sel;

    cond_sel_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (winner),
        .any    (any)
    );

    // Operand slice of the current winner.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        c_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == IDW'(i)) begin
                a_sel = a_in[i*WIDTH +: WIDTH];
                b_sel = b_in[i*WIDTH +: WIDTH];
                c_sel = c_in[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        grant_d   = '0;
        y_out_d   = y_out_q;
        y_id_d    = y_id_q;
        y_valid_d = y_valid_q;
        ptr_d     = ptr_q;
        a_lat_d   = a_lat_q;
        b_lat_d   = b_lat_q;
        c_lat_d   = c_lat_q;
        id_lat_d  = id_lat_q;

        case (state_q)
            ST_IDLE: begin
                if (any) begin
                    grant_d  = NREQ'(1) << winner;
                    a_lat_d  = a_sel;
                    b_lat_d  = b_sel;
                    c_lat_d  = c_sel;
                    id_lat_d = winner;
                    ptr_d    = winner + IDW'(1);
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // c is tested as a whole vector, not bitwise.
                y_out_d   = (c_lat_q != '0) ? a_lat_q : b_lat_q;
                y_id_d    = id_lat_q;
                y_valid_d = 1'b1;
                state_d   = ST_HOLD;
            end
            ST_HOLD: begin
                if (y_ready) begin
                    y_valid_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                y_valid_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            y_out_q   <= '0;
            y_id_q    <= '0;
            y_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            ptr_q     <= '0;
            a_lat_q   <= '0;
            b_lat_q   <= '0;
            c_lat_q   <= '0;
            id_lat_q  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            y_out_q   <= y_out_d;
            y_id_q    <= y_id_d;
            y_valid_q <= y_valid_d;
            busy_q    <= busy_d;
            ptr_q     <= ptr_d;
            a_lat_q   <= a_lat_d;
            b_lat_q   <= b_lat_d;
            c_lat_q   <= c_lat_d;
            id_lat_q  <= id_lat_d;
        end
    end

    assign grant   = grant_q;
    assign y_out   = y_out_q;
    assign y_id    = y_id_q;
    assign y_valid = y_valid_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_cond_sel_arbiter.sv
// Directed self-checking bench for cond_sel_arbiter (NREQ=4, WIDTH=4).
module tb_cond_sel_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] a_in, b_in, c_in;
    logic [3:0]  grant;
    logic [3:0]  y_out;
    logic [1:0]  y_id;
    logic        y_valid;
    logic        y_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    cond_sel_arbiter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .a_in    (a_in),
        .b_in    (b_in),
        .c_in    (c_in),
        .grant   (grant),
        .y_out   (y_out),
        .y_id    (y_id),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        a_in[i*4 +: 4] = a;
        b_in[i*4 +: 4] = b;
        c_in[i*4 +: 4] = c;
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] exp_id[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] exp_y [5] = '{4'hF, 4'h1, 4'hF, 4'h3, 4'hF};

    initial begin
        rst_n   = 1'b0;
        req     = '0;
        a_in    = '0;
        b_in    = '0;
        c_in    = '0;
        y_ready = 1'b1;
        #3;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_y_out", 32'(y_out), 32'h0);
        check("rst_y_id", 32'(y_id), 32'h0);
        check("rst_y_valid", 32'(y_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single request, nonzero condition selects a.
        set_ops(0, 4'b1110, 4'b0101, 4'b0110);
        req = 4'b0001;
        step();
        check("single_grant", 32'(grant), 32'h1);
        check("single_valid_early", 32'(y_valid), 32'h0);
        check("single_busy", 32'(busy), 32'h1);
        req = 4'b0000;
        step();
        check("single_grant_drop", 32'(grant), 32'h0);
        check("single_valid", 32'(y_valid), 32'h1);
        check("single_y_out", 32'(y_out), 32'hE);
        check("single_y_id", 32'(y_id), 32'h0);
        step();
        check("single_valid_clr", 32'(y_valid), 32'h0);
        check("single_busy_clr", 32'(busy), 32'h0);
        check("single_y_out_kept", 32'(y_out), 32'hE);

        // Zero condition selects b; grant lasts one cycle.
        set_ops(1, 4'b1110, 4'b0101, 4'b0000);
        req = 4'b0010;
        step();
        check("zero_grant", 32'(grant), 32'h2);
        req = 4'b0000;
        step();
        check("zero_grant_pulse", 32'(grant), 32'h0);
        check("zero_y_out", 32'(y_out), 32'h5);
        check("zero_y_id", 32'(y_id), 32'h1);
        step();

        // Fairness from ptr=0 with all requests held.
        pulse_reset();
        for (int i = 0; i < 4; i++) set_ops(i, 4'(i), 4'hF, 4'(i % 2));
        req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            step();
            check($sformatf("fair_grant%0d", r), 32'(grant), 32'(exp_g[r]));
            step();
            check($sformatf("fair_nogrant%0d", r), 32'(grant), 32'h0);
            check($sformatf("fair_id%0d", r), 32'(y_id), 32'(exp_id[r]));
            check($sformatf("fair_y%0d", r), 32'(y_out), 32'(exp_y[r]));
            step();
            check($sformatf("fair_gap%0d", r), 32'(grant), 32'h0);
        end
        req = 4'b0000;
        step();

        // Backpressure: result held stable, new request and operand change ignored.
        set_ops(2, 4'hA, 4'h3, 4'h1);
        y_ready = 1'b0;
        req = 4'b0100;
        step();
        check("bp_grant", 32'(grant), 32'h4);
        req = 4'b0000;
        step();
        check("bp_valid", 32'(y_valid), 32'h1);
        check("bp_y_out", 32'(y_out), 32'hA);
        a_in[8 +: 4] = 4'h7;
        req = 4'b1000;
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("bp_hold_valid%0d", k), 32'(y_valid), 32'h1);
            check($sformatf("bp_hold_y%0d", k), 32'(y_out), 32'hA);
            check($sformatf("bp_hold_id%0d", k), 32'(y_id), 32'h2);
            check($sformatf("bp_hold_grant%0d", k), 32'(grant), 32'h0);
        end
        y_ready = 1'b1;
        step();
        check("bp_release_valid", 32'(y_valid), 32'h0);
        check("bp_release_grant", 32'(grant), 32'h0);
        step();
        check("bp_next_grant", 32'(grant), 32'h8);
        req = 4'b0000;
        step();
        check("bp_next_id", 32'(y_id), 32'h3);
        check("bp_next_y", 32'(y_out), 32'h3);
        step();

        // Operand capture: condition changed after grant has no effect.
        set_ops(0, 4'b1110, 4'b0101, 4'b0110);
        req = 4'b0001;
        step();
        check("cap_grant", 32'(grant), 32'h1);
        c_in[0 +: 4] = 4'b0000;
        req = 4'b0000;
        step();
        check("cap_y_out", 32'(y_out), 32'hE);
        step();

        // Async reset while holding a result.
        set_ops(1, 4'b1110, 4'b0101, 4'b0000);
        y_ready = 1'b0;
        req = 4'b0010;
        step();
        check("ar_grant", 32'(grant), 32'h2);
        req = 4'b0000;
        step();
        check("ar_valid_before", 32'(y_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(y_valid), 32'h0);
        check("ar_busy", 32'(busy), 32'h0);
        check("ar_grant_clr", 32'(grant), 32'h0);
        check("ar_y_out", 32'(y_out), 32'h0);
        #1 rst_n = 1'b1;
        y_ready = 1'b1;
        step();
        check("ar_no_result", 32'(y_valid), 32'h0);
        check("ar_idle_busy", 32'(busy), 32'h0);
        req = 4'b0101;
        step();
        check("ar_ptr_zero", 32'(grant), 32'h1);
        req = 4'b0000;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
